fpnew_result_reorder: RTL and testbench
=======================================

Name: fpnew_result_reorder

Overview:
- Collects results from opgroup blocks back at the issue side of the FPU and retires them in issue order.
- At issue, allocates a slot ID that travels with the operation as its tag.
- Accepts out-of-order writebacks from NumPorts result ports, each addressed by ID.
- Presents results one at a time, oldest first, on a valid/ready output.

Parameters:
- Width, 32, result data width in bits.
- Depth, 4, number of reorder slots; power of two, minimum 2.
- NumPorts, 2, number of writeback ports (one per opgroup block).
- TagType, logic, user tag captured at issue and returned at retire.
- IdWidth (localparam), $clog2(Depth), width of the slot ID.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush; discards all slots.
- issue_valid_i  in  1  request to allocate a slot.
- issue_ready_o  out  1  a free slot is available.
- issue_tag_i  in  TagType  user tag stored in the slot.
- issue_id_o  out  IdWidth  ID of the slot allocated on an issue handshake.
- wb_valid_i  in  NumPorts  writeback valid, one bit per port.
- wb_id_i  in  NumPorts x IdWidth  slot ID written by each port.
- wb_result_i  in  NumPorts x Width  result data.
- wb_status_i  in  NumPorts x 5  fpnew_pkg::status_t flags.
- wb_ext_bit_i  in  NumPorts  extension bit.
- out_valid_o  out  1  head slot is complete.
- out_ready_i  in  1  consumer accepts the head slot.
- result_o  out  Width  head result.
- status_o  out  5  head status.
- extension_bit_o  out  1  head extension bit.
- tag_o  out  TagType  head user tag.
- busy_o  out  1  at least one slot is allocated.
- wb_err_o  out  1  sticky protocol error flag.

Behaviour:
- State:
  - Per slot: alloc and done bits, plus result, status, ext_bit and tag storage.
  - Write pointer wptr and read pointer rptr, each IdWidth bits, wrapping modulo Depth.
  - Occupancy counter cnt, IdWidth+1 bits, range 0..Depth.
- Reset (async, rst_ni=0):
  - All alloc and done bits clear; wptr, rptr and cnt are 0.
  - issue_ready_o=1, out_valid_o=0, busy_o=0, wb_err_o=0, issue_id_o=0.
  - Data outputs are 0.
- Issue:
  - issue_ready_o = (cnt != Depth). It does not depend on out_ready_i.
  - issue_id_o = wptr at all times.
  - On handshake: alloc[wptr] is set, done[wptr] is cleared, tag is stored, and wptr increments.
- Writeback:
  - Ports are always accepted; no backpressure.
  - A valid write to a slot with alloc=1 and done=0 stores the data and sets done at the clock edge.
  - A write to a slot with alloc=0, or with done already set, is dropped and sets wb_err_o.
  - Two ports writing the same ID in one cycle: the lowest-index port wins, and wb_err_o is set.
- Retire:
  - out_valid_o = alloc[rptr] & done[rptr], driven from registers.
  - Writeback-to-out_valid_o latency is therefore 1 cycle.
  - On out_valid_o & out_ready_i: alloc[rptr] and done[rptr] clear and rptr increments.
  - Output data is held stable while out_valid_o=1 and out_ready_i=0.
- Counter: cnt increments on issue only, decrements on retire only, and is unchanged when both happen in the same cycle.
  - Full with a simultaneous retire: issue_ready_o stays 0 in that cycle and the slot becomes free the next cycle.
- Wrap-around: pointers roll over from Depth-1 to 0. A slot ID is reused only after that slot has retired.
- Flush:
  - Clears all alloc and done bits and resets wptr, rptr and cnt to 0.
  - Issue, writeback and retire handshakes in the flush cycle are ignored.
  - wb_err_o is preserved; only reset clears it.
- busy_o = (cnt != 0).

Optional Feature:
- Macro: FPNEW_RESULT_REORDER_BYPASS_EN.
- When defined:
  - If the head slot is allocated and not yet done, and a valid writeback targets rptr, out_valid_o asserts in that same cycle.
  - Output data is forwarded combinationally from the writing port.
  - If out_ready_i=1, the slot retires without its done bit ever being stored.
  - Writeback-to-output latency is 0 cycles for the head slot only.
- When undefined: latency is always 1 cycle, and outputs have no combinational path from the wb_* inputs.

Test Plan:
- Issue 3 ops (IDs 0,1,2), then write back IDs in order 2,0,1 with results 0xC, 0xA, 0xB -> out_valid_o rises 1 cycle after the ID 0 write. Retire order is 0xA, 0xB, 0xC with the matching tags.
- Issue 4 ops with Depth=4 -> issue_ready_o=0 after the 4th. Retire one -> issue_ready_o=1 next cycle. The next issue_id_o is 0, exercising wrap.
- Hold out_ready_i=0 for 5 cycles with the head done -> result_o, status_o and tag_o stay stable and out_valid_o stays 1.
- Ports 0 and 1 both write ID 1 (data 0x11 vs 0x22) -> slot holds 0x11 and wb_err_o=1. A later write to unallocated ID 3 keeps wb_err_o=1.
- Issue 2 ops, write back one, assert flush_i -> next cycle cnt=0, busy_o=0, out_valid_o=0, issue_id_o=0.
- With FPNEW_RESULT_REORDER_BYPASS_EN: head ID 0 pending, write back 0x5 with out_ready_i=1 -> out_valid_o=1 and result_o=0x5 in the same cycle, and the slot retires at that edge. Without the macro, out_valid_o asserts 1 cycle later.

Source files
------------

// File: rtl/fpnew_result_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fpnew_result_reorder
// Brief    : Reorder buffer that retires out-of-order FPU opgroup results in
//            issue order. Optional head bypass: FPNEW_RESULT_REORDER_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fpnew_result_reorder #(
  parameter int unsigned Width    = 32,
  parameter int unsigned Depth    = 4,
  parameter int unsigned NumPorts = 2,
  parameter type         TagType  = logic,
  localparam int unsigned IdWidth = $clog2(Depth)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic                               issue_valid_i,
  output logic                               issue_ready_o,
  input  TagType                             issue_tag_i,
  output logic [IdWidth-1:0]                 issue_id_o,
  input  logic [NumPorts-1:0]                wb_valid_i,
  input  logic [NumPorts-1:0][IdWidth-1:0]   wb_id_i,
  input  logic [NumPorts-1:0][Width-1:0]     wb_result_i,
  input  logic [NumPorts-1:0][4:0]           wb_status_i,
  input  logic [NumPorts-1:0]                wb_ext_bit_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [Width-1:0]                   result_o,
  output logic [4:0]                         status_o,
  output logic                               extension_bit_o,
  output TagType                             tag_o,
  output logic                               busy_o,
  output logic                               wb_err_o
);

  localparam int unsigned PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam logic [IdWidth:0] c_FULL = (IdWidth+1)'(Depth);

  logic [Depth-1:0]   r_alloc;
  logic [Depth-1:0]   r_done;
  logic [Width-1:0]   r_result [Depth];
  logic [4:0]         r_status [Depth];
  logic [Depth-1:0]   r_ext;
  TagType             r_tag    [Depth];
  logic [IdWidth-1:0] r_wptr;
  logic [IdWidth-1:0] r_rptr;
  logic [IdWidth:0]   r_cnt;
  logic               r_err;

  logic [Depth-1:0]   w_hit;
  logic [Depth-1:0]   w_slot_wr;
  logic [PortW-1:0]   w_slot_port [Depth];
  logic               w_err;
  logic               w_issue;
  logic               w_retire;
  logic               w_head_done;

  // Ports are scanned lowest first, so the first claimant of a slot wins and
  // any later port hitting the same ID in this cycle is flagged as an error.
  always_comb begin
    w_hit     = '0;
    w_slot_wr = '0;
    w_err     = 1'b0;
    for (int s = 0; s < Depth; s++) w_slot_port[s] = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (wb_valid_i[p]) begin
        if (w_hit[wb_id_i[p]]) begin
          w_err = 1'b1;
        end else begin
          w_hit[wb_id_i[p]] = 1'b1;
          if (r_alloc[wb_id_i[p]] && !r_done[wb_id_i[p]]) begin
            w_slot_wr[wb_id_i[p]]   = 1'b1;
            w_slot_port[wb_id_i[p]] = PortW'(p);
          end else begin
            w_err = 1'b1;
          end
        end
      end
    end
  end

  assign w_head_done   = r_alloc[r_rptr] & r_done[r_rptr];
  assign issue_ready_o = (r_cnt != c_FULL);
  assign issue_id_o    = r_wptr;
  assign busy_o        = (r_cnt != '0);
  assign wb_err_o      = r_err;
  assign tag_o         = r_tag[r_rptr];
  assign w_issue       = issue_valid_i & issue_ready_o;
  assign w_retire      = out_valid_o & out_ready_i;

`ifdef FPNEW_RESULT_REORDER_BYPASS_EN
  logic             w_byp;
  logic [PortW-1:0] w_byp_port;

  assign w_byp           = w_slot_wr[r_rptr];
  assign w_byp_port      = w_slot_port[r_rptr];
  assign out_valid_o     = w_head_done | w_byp;
  assign result_o        = w_byp ? wb_result_i[w_byp_port]  : r_result[r_rptr];
  assign status_o        = w_byp ? wb_status_i[w_byp_port]  : r_status[r_rptr];
  assign extension_bit_o = w_byp ? wb_ext_bit_i[w_byp_port] : r_ext[r_rptr];
`else
  assign out_valid_o     = w_head_done;
  assign result_o        = r_result[r_rptr];
  assign status_o        = r_status[r_rptr];
  assign extension_bit_o = r_ext[r_rptr];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_alloc <= '0;
      r_done  <= '0;
      r_ext   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      for (int s = 0; s < Depth; s++) begin
        r_result[s] <= '0;
        r_status[s] <= '0;
        r_tag[s]    <= '0;
      end
    end else if (flush_i) begin
      r_alloc <= '0;
      r_done  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_err) r_err <= 1'b1;
      for (int s = 0; s < Depth; s++) begin
        if (w_slot_wr[s]) begin
          r_done[s]   <= 1'b1;
          r_result[s] <= wb_result_i[w_slot_port[s]];
          r_status[s] <= wb_status_i[w_slot_port[s]];
          r_ext[s]    <= wb_ext_bit_i[w_slot_port[s]];
        end
      end
      if (w_issue) begin
        r_alloc[r_wptr] <= 1'b1;
        r_done[r_wptr]  <= 1'b0;
        r_tag[r_wptr]   <= issue_tag_i;
        r_wptr          <= r_wptr + IdWidth'(1);
      end
      // Placed after the writeback loop so a bypassed head never keeps done.
      if (w_retire) begin
        r_alloc[r_rptr] <= 1'b0;
        r_done[r_rptr]  <= 1'b0;
        r_rptr          <= r_rptr + IdWidth'(1);
      end
      if (w_issue && !w_retire)      r_cnt <= r_cnt + (IdWidth+1)'(1);
      else if (!w_issue && w_retire) r_cnt <= r_cnt - (IdWidth+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpnew_result_reorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpnew_result_reorder
// Brief    : Directed table-driven bench for fpnew_result_reorder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpnew_result_reorder;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int NP = 2;
  localparam int IW = 2;
  typedef logic [7:0] tag_t;

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic                    flush_i;
  logic                    issue_valid_i;
  logic                    issue_ready_o;
  tag_t                    issue_tag_i;
  logic [IW-1:0]           issue_id_o;
  logic [NP-1:0]           wb_valid_i;
  logic [NP-1:0][IW-1:0]   wb_id_i;
  logic [NP-1:0][W-1:0]    wb_result_i;
  logic [NP-1:0][4:0]      wb_status_i;
  logic [NP-1:0]           wb_ext_bit_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [W-1:0]            result_o;
  logic [4:0]              status_o;
  logic                    extension_bit_o;
  tag_t                    tag_o;
  logic                    busy_o;
  logic                    wb_err_o;

  fpnew_result_reorder #(
    .Width(W), .Depth(D), .NumPorts(NP), .TagType(tag_t)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_tag_i(issue_tag_i), .issue_id_o(issue_id_o),
    .wb_valid_i(wb_valid_i), .wb_id_i(wb_id_i), .wb_result_i(wb_result_i),
    .wb_status_i(wb_status_i), .wb_ext_bit_i(wb_ext_bit_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .status_o(status_o),
    .extension_bit_o(extension_bit_o), .tag_o(tag_o),
    .busy_o(busy_o), .wb_err_o(wb_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        iv;   logic [7:0]  tag;
    logic [1:0]  wv;   logic [1:0]  id0; logic [31:0] r0;
    logic [1:0]  id1;  logic [31:0] r1;
    logic        rdy;  logic        fl;
    logic        e_ir; logic [1:0]  e_id; logic e_ov;
    logic [31:0] e_res; logic [7:0] e_tag; logic e_busy; logic e_err;
  } vec_t;

  vec_t tv [27];
  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(
    input logic iv, input logic [7:0] tag, input logic [1:0] wv,
    input logic [1:0] id0, input logic [31:0] r0,
    input logic [1:0] id1, input logic [31:0] r1,
    input logic rdy, input logic fl,
    input logic e_ir, input logic [1:0] e_id, input logic e_ov,
    input logic [31:0] e_res, input logic [7:0] e_tag,
    input logic e_busy, input logic e_err);
    vec_t v;
    v.iv = iv; v.tag = tag; v.wv = wv; v.id0 = id0; v.r0 = r0;
    v.id1 = id1; v.r1 = r1; v.rdy = rdy; v.fl = fl;
    v.e_ir = e_ir; v.e_id = e_id; v.e_ov = e_ov; v.e_res = e_res;
    v.e_tag = e_tag; v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    flush_i = 0; issue_valid_i = 0; issue_tag_i = '0; out_ready_i = 0;
    wb_valid_i = '0; wb_id_i = '0; wb_result_i = '0;
    wb_status_i = '0; wb_ext_bit_i = '0;
  endtask

  // Status and extension bit are derived from the result so each port's
  // sideband data is distinguishable.
  task automatic drive_wb(input int p, input logic [1:0] id, input logic [31:0] r);
    wb_valid_i[p]   = 1'b1;
    wb_id_i[p]      = id;
    wb_result_i[p]  = r;
    wb_status_i[p]  = r[4:0] ^ 5'h1F;
    wb_ext_bit_i[p] = r[0];
  endtask

  task automatic chk_head(input string nm, input logic [31:0] r, input logic [7:0] t);
    chk({nm, ".result"}, result_o, r);
    chk({nm, ".status"}, {27'd0, status_o}, {27'd0, r[4:0] ^ 5'h1F});
    chk({nm, ".ext"}, {31'd0, extension_bit_o}, {31'd0, r[0]});
    chk({nm, ".tag"}, {24'd0, tag_o}, {24'd0, t});
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".ready"}, {31'd0, issue_ready_o}, 32'd1);
    chk({nm, ".valid"}, {31'd0, out_valid_o}, 32'd0);
    chk({nm, ".busy"}, {31'd0, busy_o}, 32'd0);
    chk({nm, ".err"}, {31'd0, wb_err_o}, 32'd0);
    chk({nm, ".id"}, {30'd0, issue_id_o}, 32'd0);
    chk({nm, ".result"}, result_o, 32'd0);
    chk({nm, ".status"}, {27'd0, status_o}, 32'd0);
    chk({nm, ".ext"}, {31'd0, extension_bit_o}, 32'd0);
    chk({nm, ".tag"}, {24'd0, tag_o}, 32'd0);
  endtask

  initial begin
    // In-order retire from out-of-order writeback
    tv[0]  = mk(1,8'h10,2'b00,0,0,0,0,         0,0, 1,1,0,0,0,1,0);
    tv[1]  = mk(1,8'h11,2'b00,0,0,0,0,         0,0, 1,2,0,0,0,1,0);
    tv[2]  = mk(1,8'h12,2'b00,0,0,0,0,         0,0, 1,3,0,0,0,1,0);
    tv[3]  = mk(0,0,2'b01,2,32'hC,0,0,         0,0, 1,3,0,0,0,1,0);
    tv[4]  = mk(0,0,2'b10,0,0,0,32'hA,         0,0, 1,3,1,32'hA,8'h10,1,0);
    tv[5]  = mk(0,0,2'b01,1,32'hB,0,0,         1,0, 1,3,1,32'hB,8'h11,1,0);
    tv[6]  = mk(0,0,2'b00,0,0,0,0,             1,0, 1,3,1,32'hC,8'h12,1,0);
    tv[7]  = mk(0,0,2'b00,0,0,0,0,             1,0, 1,3,0,0,0,0,0);
    // Flush with live issue/writeback/retire requests
    tv[8]  = mk(1,8'h30,2'b00,0,0,0,0,         0,0, 1,0,0,0,0,1,0);
    tv[9]  = mk(1,8'h31,2'b00,0,0,0,0,         0,0, 1,1,0,0,0,1,0);
    tv[10] = mk(0,0,2'b01,3,32'h44,0,0,        0,0, 1,1,1,32'h44,8'h30,1,0);
    tv[11] = mk(1,8'h77,2'b01,0,32'h99,0,0,    1,1, 1,0,0,0,0,0,0);
    // Fill, full, retire while full, wrap
    tv[12] = mk(1,8'h40,2'b00,0,0,0,0,         0,0, 1,1,0,0,0,1,0);
    tv[13] = mk(1,8'h41,2'b00,0,0,0,0,         0,0, 1,2,0,0,0,1,0);
    tv[14] = mk(1,8'h42,2'b00,0,0,0,0,         0,0, 1,3,0,0,0,1,0);
    tv[15] = mk(1,8'h43,2'b00,0,0,0,0,         0,0, 0,0,0,0,0,1,0);
    tv[16] = mk(1,8'h99,2'b10,0,0,0,32'h55,    0,0, 0,0,1,32'h55,8'h40,1,0);
    tv[17] = mk(1,8'h98,2'b00,0,0,0,0,         1,0, 1,0,0,0,0,1,0);
    tv[18] = mk(1,8'h50,2'b00,0,0,0,0,         0,0, 0,1,0,0,0,1,0);
    // Same-ID collision, then hold under backpressure
    tv[19] = mk(0,0,2'b11,1,32'h11,1,32'h22,   0,0, 0,1,1,32'h11,8'h41,1,1);
    for (int i = 20; i < 25; i++)
      tv[i] = mk(0,0,2'b00,0,0,0,0,            0,0, 0,1,1,32'h11,8'h41,1,1);
    tv[25] = mk(0,0,2'b00,0,0,0,0,             1,0, 1,1,0,0,0,1,1);
    tv[26] = mk(0,0,2'b01,1,32'h77,0,0,        0,0, 1,1,0,0,0,1,1);

    idle();
    #12;
    chk_reset("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 27; i++) begin
      idle();
      issue_valid_i = tv[i].iv;
      issue_tag_i   = tv[i].tag;
      out_ready_i   = tv[i].rdy;
      flush_i       = tv[i].fl;
      if (tv[i].wv[0]) drive_wb(0, tv[i].id0, tv[i].r0);
      if (tv[i].wv[1]) drive_wb(1, tv[i].id1, tv[i].r1);
      @(negedge clk_i);
      chk($sformatf("v%0d.ready", i), {31'd0, issue_ready_o}, {31'd0, tv[i].e_ir});
      chk($sformatf("v%0d.id", i), {30'd0, issue_id_o}, {30'd0, tv[i].e_id});
      chk($sformatf("v%0d.valid", i), {31'd0, out_valid_o}, {31'd0, tv[i].e_ov});
      chk($sformatf("v%0d.busy", i), {31'd0, busy_o}, {31'd0, tv[i].e_busy});
      chk($sformatf("v%0d.err", i), {31'd0, wb_err_o}, {31'd0, tv[i].e_err});
      if (tv[i].e_ov) chk_head($sformatf("v%0d", i), tv[i].e_res, tv[i].e_tag);
    end

    // Mid-run reset, then a write to an already-done slot
    idle();
    rst_ni = 1'b0;
    #1;
    chk_reset("reset2");
    @(negedge clk_i);
    rst_ni = 1'b1;
    issue_valid_i = 1; issue_tag_i = 8'h5A;
    @(negedge clk_i);
    idle();
    drive_wb(0, 2'd0, 32'hA1);
    @(negedge clk_i);
    chk("done_wr.err0", {31'd0, wb_err_o}, 32'd0);
    chk_head("done_wr.first", 32'hA1, 8'h5A);
    idle();
    drive_wb(1, 2'd0, 32'hB2);
    @(negedge clk_i);
    chk("done_wr.err1", {31'd0, wb_err_o}, 32'd1);
    chk_head("done_wr.kept", 32'hA1, 8'h5A);

    // Write to an unallocated slot on a clean error flag
    idle();
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive_wb(0, 2'd3, 32'h33);
    @(negedge clk_i);
    chk("unalloc.err", {31'd0, wb_err_o}, 32'd1);
    chk("unalloc.valid", {31'd0, out_valid_o}, 32'd0);
    chk("unalloc.busy", {31'd0, busy_o}, 32'd0);

    // Head-slot writeback latency
    idle();
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    issue_valid_i = 1; issue_tag_i = 8'h61;
    @(negedge clk_i);
    idle();
    drive_wb(0, 2'd0, 32'h5);
    out_ready_i = 1;
    #1;
`ifdef FPNEW_RESULT_REORDER_BYPASS_EN
    chk("byp.same_cycle_valid", {31'd0, out_valid_o}, 32'd1);
    chk_head("byp.same_cycle", 32'h5, 8'h61);
`else
    chk("byp.same_cycle_valid", {31'd0, out_valid_o}, 32'd0);
`endif
    @(negedge clk_i);
`ifdef FPNEW_RESULT_REORDER_BYPASS_EN
    chk("byp.next_valid", {31'd0, out_valid_o}, 32'd0);
    chk("byp.next_busy", {31'd0, busy_o}, 32'd0);
`else
    chk("byp.next_valid", {31'd0, out_valid_o}, 32'd1);
    chk("byp.next_busy", {31'd0, busy_o}, 32'd1);
    chk_head("byp.next", 32'h5, 8'h61);
`endif
    idle();
    @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
